// File: rtl/imem_fetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Build option: IMEM_ACCESS_FAULT_EN enables the out-of-range check.
package imem_fetch_resp_pkg;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } if_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        misalign;
      logic        fault;
   } rsp_t;

   // True when the byte address lies beyond the SRAM word range.
   function automatic logic out_of_range(input logic [31:0] addr, input int unsigned addr_w);
      return (addr >> (addr_w + 2)) != 32'd0;
   endfunction

endpackage

// File: rtl/imem_fetch_resp_fifo.sv
// Generic synchronous FIFO with sync clear; data appears at head the cycle after push.
// No internal overflow guard: the caller must never push when full or pop when empty.
module imem_fetch_resp_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_dat,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head_dat,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (i_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (i_push && !i_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!i_push && i_pop) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge i_clk) begin
      if (i_push) mem_q[wr_ptr_q] <= i_push_dat;
   end

   assign o_head_dat = mem_q[rd_ptr_q];
   assign o_count    = cnt_q;
   assign o_empty    = (cnt_q == '0);

endmodule

// File: rtl/imem_fetch_resp.sv
// Instruction-fetch responder: 1-cycle SRAM read, in-order responses, flush on redirect.
// Latency 1 (bypass when queue empty); ready drops once queued+in-flight fills FIFO_DEPTH. Option: IMEM_ACCESS_FAULT_EN.
module imem_fetch_resp
   import imem_fetch_resp_pkg::*;
#(
   parameter int          ADDR_W     = 10,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [31:0]       i_req_addr,
   input  logic              i_flush,
   output logic              o_mem_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [31:0]       i_mem_rdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [31:0]       o_rsp_instr,
   output logic [31:0]       o_rsp_addr,
   output logic              o_rsp_misalign
`ifdef IMEM_ACCESS_FAULT_EN
   ,
   output logic              o_rsp_fault
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   if_state_e   state_q, state_d;
   logic        inf_vld_q, inf_vld_d;
   logic [31:0] inf_addr_q, inf_addr_d;
   logic        inf_nop_q, inf_nop_d;
   logic        inf_mis_q, inf_mis_d;
   logic        inf_flt_q, inf_flt_d;

   logic             mis_w, oor_w, acc_w;
   logic [CNT_W-1:0] fifo_cnt_w, occ_w;
   logic             fifo_empty_w, fifo_push_w, fifo_pop_w;
   logic             rsp_vld_w, pop_w, bypass_pop_w;
   rsp_t             inf_ent_w, fifo_head_w, rsp_src_w;

   assign mis_w = (i_req_addr[1:0] != 2'b00);
`ifdef IMEM_ACCESS_FAULT_EN
   assign oor_w = out_of_range(i_req_addr, ADDR_W);
`else
   assign oor_w = 1'b0;
`endif

   // In-flight slot is counted so a push can never find the FIFO full.
   assign occ_w       = fifo_cnt_w + CNT_W'(inf_vld_q);
   assign o_req_ready = !i_rst && (state_q == S_RUN) && !i_flush && (occ_w < CNT_W'(FIFO_DEPTH));
   assign acc_w       = i_req_valid && o_req_ready;
   assign o_mem_en    = acc_w && !mis_w && !oor_w;
   assign o_mem_addr  = i_req_addr[ADDR_W+1:2];

   always_comb begin
      state_d    = state_q;
      inf_vld_d  = acc_w;
      inf_addr_d = inf_addr_q;
      inf_nop_d  = inf_nop_q;
      inf_mis_d  = inf_mis_q;
      inf_flt_d  = inf_flt_q;
      if (acc_w) begin
         inf_addr_d = i_req_addr;
         inf_nop_d  = mis_w || oor_w;
         inf_mis_d  = mis_w;
         inf_flt_d  = oor_w;
      end
      case (state_q)
         S_RUN:   if (i_flush) state_d = S_FLUSH;
         S_FLUSH: if (!i_flush) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_RUN;
         inf_vld_q  <= 1'b0;
         inf_addr_q <= '0;
         inf_nop_q  <= 1'b0;
         inf_mis_q  <= 1'b0;
         inf_flt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         inf_vld_q  <= inf_vld_d;
         inf_addr_q <= inf_addr_d;
         inf_nop_q  <= inf_nop_d;
         inf_mis_q  <= inf_mis_d;
         inf_flt_q  <= inf_flt_d;
      end
   end

   always_comb begin
      inf_ent_w          = '0;
      inf_ent_w.instr    = inf_nop_q ? NOP_INSTR : i_mem_rdata;
      inf_ent_w.addr     = inf_addr_q;
      inf_ent_w.misalign = inf_mis_q;
      inf_ent_w.fault    = inf_flt_q;
   end

   // With the queue empty the in-flight word is presented directly; once it
   // lands in the FIFO the head carries the same value, so outputs stay stable.
   assign rsp_src_w    = fifo_empty_w ? inf_ent_w : fifo_head_w;
   assign rsp_vld_w    = !i_rst && (!fifo_empty_w || inf_vld_q);
   assign pop_w        = rsp_vld_w && i_rsp_ready && !i_flush;
   assign bypass_pop_w = pop_w && fifo_empty_w;
   assign fifo_pop_w   = pop_w && !fifo_empty_w;
   assign fifo_push_w  = inf_vld_q && !i_flush && !i_rst && !bypass_pop_w;

   imem_fetch_resp_fifo #(
      .WIDTH ($bits(rsp_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (i_flush),
      .i_push     (fifo_push_w),
      .i_push_dat (inf_ent_w),
      .i_pop      (fifo_pop_w),
      .o_head_dat (fifo_head_w),
      .o_count    (fifo_cnt_w),
      .o_empty    (fifo_empty_w)
   );

   assign o_rsp_valid    = rsp_vld_w;
   assign o_rsp_instr    = rsp_vld_w ? rsp_src_w.instr    : 32'd0;
   assign o_rsp_addr     = rsp_vld_w ? rsp_src_w.addr     : 32'd0;
   assign o_rsp_misalign = rsp_vld_w ? rsp_src_w.misalign : 1'b0;
`ifdef IMEM_ACCESS_FAULT_EN
   assign o_rsp_fault    = rsp_vld_w ? rsp_src_w.fault    : 1'b0;
`else
   logic unused_fault;
   assign unused_fault = rsp_src_w.fault;
`endif

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Directed bench for imem_fetch_resp with a 1-cycle SRAM model (word k holds 0x1000+k).
module tb_imem_fetch_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        flush;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_misalign;
`ifdef IMEM_ACCESS_FAULT_EN
   logic        rsp_fault;
`endif

   int n_chk = 0;
   int n_bad = 0;

   imem_fetch_resp dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_addr     (req_addr),
      .i_flush        (flush),
      .o_mem_en       (mem_en),
      .o_mem_addr     (mem_addr),
      .i_mem_rdata    (mem_rdata),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_instr    (rsp_instr),
      .o_rsp_addr     (rsp_addr),
      .o_rsp_misalign (rsp_misalign)
`ifdef IMEM_ACCESS_FAULT_EN
      ,
      .o_rsp_fault    (rsp_fault)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= 32'h1000 + {22'd0, mem_addr};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] instr, input logic [31:0] addr);
      chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_instr"}, rsp_instr, instr);
      chk({tag, "_addr"}, rsp_addr, addr);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; flush = 1'b0; rsp_ready = 1'b0;

      // reset
      step(); step();
      @(negedge clk);
      chk("rst_vld", 32'(rsp_valid), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_instr", rsp_instr, 32'd0);
      step(); rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_vld", 32'(rsp_valid), 32'd0);

      // back-to-back stream
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         req_valid = (i < 3);
         req_addr  = 32'(4 * i);
         @(negedge clk);
         if (i < 3) begin
            chk("b2b_mem_en", 32'(mem_en), 32'd1);
            chk("b2b_mem_addr", 32'(mem_addr), 32'(i));
         end
         if (i > 0) chk_rsp("b2b", 32'h1000 + 32'(i - 1), 32'(4 * (i - 1)));
      end
      step(); req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_drained", 32'(rsp_valid), 32'd0);

      // backpressure
      rsp_ready = 1'b0;
      step(); req_valid = 1'b1; req_addr = 32'h10;
      @(negedge clk);
      chk("bp_rdy1", 32'(req_ready), 32'd1);
      step(); req_addr = 32'h14;
      @(negedge clk);
      chk("bp_rdy2", 32'(req_ready), 32'd1);
      chk_rsp("bp_head1", 32'h1004, 32'h10);
      step(); req_addr = 32'h18;
      @(negedge clk);
      chk("bp_rdy3", 32'(req_ready), 32'd0);
      chk_rsp("bp_head2", 32'h1004, 32'h10);
      step();
      @(negedge clk);
      chk("bp_rdy4", 32'(req_ready), 32'd0);
      chk_rsp("bp_hold", 32'h1004, 32'h10);
      step(); rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_rdy5", 32'(req_ready), 32'd0);
      chk_rsp("bp_pop1", 32'h1004, 32'h10);
      step();
      @(negedge clk);
      chk("bp_rdy6", 32'(req_ready), 32'd1);
      chk_rsp("bp_pop2", 32'h1005, 32'h14);
      step(); req_valid = 1'b0;
      @(negedge clk);
      chk_rsp("bp_pop3", 32'h1006, 32'h18);
      step();
      @(negedge clk);
      chk("bp_empty", 32'(rsp_valid), 32'd0);

      // misaligned request
      step(); req_valid = 1'b1; req_addr = 32'h22;
      @(negedge clk);
      chk("mis_mem_en", 32'(mem_en), 32'd0);
      chk("mis_rdy", 32'(req_ready), 32'd1);
      step(); req_valid = 1'b0;
      @(negedge clk);
      chk_rsp("mis", 32'h0000_0013, 32'h22);
      chk("mis_flag", 32'(rsp_misalign), 32'd1);
      step();
      @(negedge clk);
      chk("mis_empty", 32'(rsp_valid), 32'd0);

      // flush: one queued, one in flight
      rsp_ready = 1'b0;
      step(); req_valid = 1'b1; req_addr = 32'h30;
      step(); req_addr = 32'h34;
      step(); req_addr = 32'h38; flush = 1'b1;
      @(negedge clk);
      chk("fl_rdy_flush", 32'(req_ready), 32'd0);
      chk("fl_mem_en", 32'(mem_en), 32'd0);
      step(); flush = 1'b0; req_addr = 32'h40;
      @(negedge clk);
      chk("fl_rdy_sflush", 32'(req_ready), 32'd0);
      chk("fl_vld_after", 32'(rsp_valid), 32'd0);
      step(); rsp_ready = 1'b1;
      @(negedge clk);
      chk("fl_rdy_run", 32'(req_ready), 32'd1);
      chk("fl_mem_addr", 32'(mem_addr), 32'h10);
      chk("fl_no_stale", 32'(rsp_valid), 32'd0);
      step(); req_valid = 1'b0;
      @(negedge clk);
      chk_rsp("fl_next", 32'h1010, 32'h40);
      step();
      @(negedge clk);
      chk("fl_empty", 32'(rsp_valid), 32'd0);

      // upper address bits: wrap without fault option, fault with it
      step(); req_valid = 1'b1; req_addr = 32'h1000;
      @(negedge clk);
`ifdef IMEM_ACCESS_FAULT_EN
      chk("oor_mem_en", 32'(mem_en), 32'd0);
      step(); req_valid = 1'b0;
      @(negedge clk);
      chk_rsp("oor", 32'h0000_0013, 32'h1000);
      chk("oor_fault", 32'(rsp_fault), 32'd1);
      chk("oor_mis", 32'(rsp_misalign), 32'd0);
`else
      chk("wrap_mem_en", 32'(mem_en), 32'd1);
      chk("wrap_mem_addr", 32'(mem_addr), 32'd0);
      step(); req_valid = 1'b0;
      @(negedge clk);
      chk_rsp("wrap", 32'h1000, 32'h1000);
      chk("wrap_mis", 32'(rsp_misalign), 32'd0);
`endif

      // reset while a read is in flight
      rsp_ready = 1'b0;
      step(); req_valid = 1'b1; req_addr = 32'h50;
      step(); req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("mrst_vld", 32'(rsp_valid), 32'd0);
      chk("mrst_rdy", 32'(req_ready), 32'd0);
      step(); rst = 1'b0;
      @(negedge clk);
      chk("mrst_vld_after", 32'(rsp_valid), 32'd0);
      chk("mrst_rdy_after", 32'(req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
